// File: rtl/cpu_pkg.sv
// Shared CPU definitions: reset/bubble defaults, PC increment and the
// fetch FSM state encoding.
package cpu_pkg;

    localparam logic [31:0] DEFAULT_RESET_PC  = 32'h0040_0000;
    localparam logic [31:0] DEFAULT_NOP_INSTR = 32'h0000_0000;
    localparam logic [31:0] PC_INCR           = 32'd4;

    typedef enum logic {
        RUN  = 1'b0,
        HALT = 1'b1
    } fetch_state_t;

endpackage

// File: rtl/if_fetch_stage_if.sv
// Bundle of the fetch stage's control inputs, instruction-memory bus and
// IF/ID outputs.
interface if_fetch_stage_if;
    import cpu_pkg::*;

    // No valid/ready pair here: stall_i is the only back-pressure and freezes
    // PC and IF/ID for the cycle it is high; if_id_valid_o marks a real
    // instruction (0 = bubble) and is accepted by ID on every non-stalled edge.
    logic         stall_i;
    logic         redirect_valid_i;
    logic [31:0]  redirect_pc_i;
    logic         halt_i;
    logic [31:0]  imem_addr_o;
    logic [31:0]  imem_instr_i;
    logic [31:0]  if_id_instr_o;
    logic [31:0]  if_id_pc_plus4_o;
    logic         if_id_valid_o;
    logic         halted_o;
    logic [31:0]  fetch_count_o;
    fetch_state_t fetch_state;

    modport master (
        input  stall_i, redirect_valid_i, redirect_pc_i, halt_i, imem_instr_i,
        output imem_addr_o, if_id_instr_o, if_id_pc_plus4_o, if_id_valid_o,
               halted_o, fetch_count_o, fetch_state
    );

    modport slave (
        output stall_i, redirect_valid_i, redirect_pc_i, halt_i, imem_instr_i,
        input  imem_addr_o, if_id_instr_o, if_id_pc_plus4_o, if_id_valid_o,
               halted_o, fetch_count_o, fetch_state
    );

endinterface

// File: rtl/if_id_reg.sv
// Pipeline register between IF and ID with reset, flush (bubble), load and
// hold. Flush has priority over load.
module if_id_reg #(
    parameter logic [31:0] NOP_INSTR = 32'h0000_0000
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        flush,
    input  logic        load,
    input  logic [31:0] next_instr,
    input  logic [31:0] next_pc_plus4,
    output logic [31:0] instr,
    output logic [31:0] pc_plus4,
    output logic        valid
);

    always_ff @(posedge clk) begin
        if (reset || flush) begin
            instr    <= NOP_INSTR;
            pc_plus4 <= 32'd0;
            valid    <= 1'b0;
        end else if (load) begin
            instr    <= next_instr;
            pc_plus4 <= next_pc_plus4;
            valid    <= 1'b1;
        end
    end

endmodule

// File: rtl/if_fetch_stage.sv
// MIPS instruction-fetch stage: PC register, run/halt FSM, fetch counter and
// the IF/ID register, with halt > redirect > stall > advance priority.
module if_fetch_stage
    import cpu_pkg::*;
#(
    parameter logic [31:0] RESET_PC  = DEFAULT_RESET_PC,
    parameter logic [31:0] NOP_INSTR = DEFAULT_NOP_INSTR
) (
    input  logic               clk,
    input  logic               reset,
    if_fetch_stage_if.master   bus
);

    fetch_state_t state;
    logic [31:0]  pc;
    logic [31:0]  pc_plus4;
    logic [31:0]  fetch_count;
    logic         running;
    logic         advance;
    logic         flush;
    logic         redirect_low_unused;

    assign pc_plus4 = pc + PC_INCR;
    assign running  = (state == RUN);

    // A halting cycle behaves like a redirect for IF/ID (bubble) but keeps the PC.
    assign flush   = !running || bus.halt_i || bus.redirect_valid_i;
    assign advance = !flush && !bus.stall_i;

    // Targets are always word aligned, so the byte offset is dropped.
    assign redirect_low_unused = ^bus.redirect_pc_i[1:0];

    always_ff @(posedge clk) begin
        if (reset) begin
            state       <= RUN;
            pc          <= RESET_PC;
            fetch_count <= 32'd0;
        end else begin
            case (state)
                RUN: begin
                    if (bus.halt_i) begin
                        state <= HALT;
                    end else if (bus.redirect_valid_i) begin
                        pc <= {bus.redirect_pc_i[31:2], 2'b00};
                    end else if (!bus.stall_i) begin
                        pc          <= pc_plus4;
                        fetch_count <= fetch_count + 32'd1;
                    end
                end
                HALT: state <= HALT;
                default: state <= RUN;
            endcase
        end
    end

    if_id_reg #(
        .NOP_INSTR(NOP_INSTR)
    ) u_if_id (
        .clk          (clk),
        .reset        (reset),
        .flush        (flush),
        .load         (advance),
        .next_instr   (bus.imem_instr_i),
        .next_pc_plus4(pc_plus4),
        .instr        (bus.if_id_instr_o),
        .pc_plus4     (bus.if_id_pc_plus4_o),
        .valid        (bus.if_id_valid_o)
    );

    assign bus.imem_addr_o   = pc;
    assign bus.halted_o      = (state == HALT);
    assign bus.fetch_count_o = fetch_count;
    assign bus.fetch_state   = state;

endmodule

// File: tb/tb_if_fetch_stage.sv
// Directed bench for if_fetch_stage: the driver queues hand-computed
// post-edge expectations, a monitor pops and compares them after each edge.
module tb_if_fetch_stage;

    logic clk;
    logic reset;
    int   n_checks;
    int   n_fail;

    // {addr, instr, pc_plus4, count, valid, halted}
    logic [129:0] exp_q[$];

    if_fetch_stage_if bus ();

    if_fetch_stage dut (
        .clk  (clk),
        .reset(reset),
        .bus  (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [31:0] imem(input logic [31:0] addr);
        case (addr)
            32'h0040_0000: return 32'h2402_0002;
            32'h0040_0004: return 32'h2408_0000;
            32'h0040_0008: return 32'h2409_000A;
            32'h0040_000C: return 32'h0109_4020;
            32'h0040_0010: return 32'h2529_0001;
            32'h0040_012C: return 32'h0C10_004B;
            32'h0040_0130: return 32'h03E0_0008;
            default:       return ~addr;
        endcase
    endfunction

    assign bus.imem_instr_i = imem(bus.imem_addr_o);

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    always @(posedge clk) begin
        #1;
        if (exp_q.size() != 0) begin
            logic [129:0] e;
            e = exp_q.pop_front();
            chk("imem_addr", bus.imem_addr_o, e[129:98]);
            chk("if_id_instr", bus.if_id_instr_o, e[97:66]);
            chk("if_id_pc_plus4", bus.if_id_pc_plus4_o, e[65:34]);
            chk("fetch_count", bus.fetch_count_o, e[33:2]);
            chk("if_id_valid", {31'd0, bus.if_id_valid_o}, {31'd0, e[1]});
            chk("halted", {31'd0, bus.halted_o}, {31'd0, e[0]});
        end
    end

    task automatic step(
        input logic        rst,
        input logic        stall,
        input logic        redir,
        input logic [31:0] rpc,
        input logic        halt,
        input logic        preload_count,
        input logic [31:0] e_addr,
        input logic [31:0] e_instr,
        input logic [31:0] e_pc4,
        input logic        e_valid,
        input logic        e_halted,
        input logic [31:0] e_cnt
    );
        @(negedge clk);
        reset                = rst;
        bus.stall_i          = stall;
        bus.redirect_valid_i = redir;
        bus.redirect_pc_i    = rpc;
        bus.halt_i           = halt;
        exp_q.push_back({e_addr, e_instr, e_pc4, e_cnt, e_valid, e_halted});
        if (preload_count) begin
            force dut.fetch_count = 32'hFFFF_FFFE;
            #1;
            release dut.fetch_count;
        end
        @(posedge clk);
    endtask

    task automatic run1(input logic [31:0] a, input logic [31:0] i, input logic [31:0] p4,
                        input logic [31:0] c);
        step(0, 0, 0, 32'd0, 0, 0, a, i, p4, 1'b1, 1'b0, c);
    endtask

    task automatic do_reset;
        step(1, 0, 0, 32'd0, 0, 0, 32'h0040_0000, 32'd0, 32'd0, 1'b0, 1'b0, 32'd0);
    endtask

    initial begin
        n_checks             = 0;
        n_fail               = 0;
        reset                = 1'b1;
        bus.stall_i          = 1'b0;
        bus.redirect_valid_i = 1'b0;
        bus.redirect_pc_i    = 32'd0;
        bus.halt_i           = 1'b0;

        do_reset;
        do_reset;

        // free run from reset
        run1(32'h0040_0004, 32'h2402_0002, 32'h0040_0004, 32'd1);
        run1(32'h0040_0008, 32'h2408_0000, 32'h0040_0008, 32'd2);
        run1(32'h0040_000C, 32'h2409_000A, 32'h0040_000C, 32'd3);
        run1(32'h0040_0010, 32'h0109_4020, 32'h0040_0010, 32'd4);

        // stall at 0x00400008
        do_reset;
        run1(32'h0040_0004, 32'h2402_0002, 32'h0040_0004, 32'd1);
        run1(32'h0040_0008, 32'h2408_0000, 32'h0040_0008, 32'd2);
        step(0, 1, 0, 32'd0, 0, 0, 32'h0040_0008, 32'h2408_0000, 32'h0040_0008, 1'b1, 1'b0, 32'd2);
        step(0, 1, 0, 32'd0, 0, 0, 32'h0040_0008, 32'h2408_0000, 32'h0040_0008, 1'b1, 1'b0, 32'd2);
        run1(32'h0040_000C, 32'h2409_000A, 32'h0040_000C, 32'd3);

        // redirect beats stall, target aligned, one bubble
        step(0, 1, 1, 32'h0040_012E, 0, 0, 32'h0040_012C, 32'd0, 32'd0, 1'b0, 1'b0, 32'd3);
        run1(32'h0040_0130, 32'h0C10_004B, 32'h0040_0130, 32'd4);
        run1(32'h0040_0134, 32'h03E0_0008, 32'h0040_0134, 32'd5);

        // halt with redirect: halt wins, then everything frozen
        step(0, 0, 1, 32'h0040_0000, 1, 0, 32'h0040_0134, 32'd0, 32'd0, 1'b0, 1'b1, 32'd5);
        step(0, 1, 1, 32'h0040_0200, 0, 0, 32'h0040_0134, 32'd0, 32'd0, 1'b0, 1'b1, 32'd5);
        step(0, 0, 0, 32'd0, 0, 0, 32'h0040_0134, 32'd0, 32'd0, 1'b0, 1'b1, 32'd5);
        step(0, 0, 1, 32'h0040_0300, 0, 0, 32'h0040_0134, 32'd0, 32'd0, 1'b0, 1'b1, 32'd5);
        do_reset;

        // PC wrap near the top of the address space
        step(0, 0, 1, 32'hFFFF_FFFC, 0, 0, 32'hFFFF_FFFC, 32'd0, 32'd0, 1'b0, 1'b0, 32'd0);
        run1(32'h0000_0000, 32'h0000_0003, 32'h0000_0000, 32'd1);
        run1(32'h0000_0004, 32'hFFFF_FFFF, 32'h0000_0004, 32'd2);

        // fetch counter wrap from a preloaded value
        step(0, 0, 0, 32'd0, 0, 1, 32'h0000_0008, 32'hFFFF_FFFB, 32'h0000_0008, 1'b1, 1'b0, 32'hFFFF_FFFF);
        run1(32'h0000_000C, 32'hFFFF_FFF7, 32'h0000_000C, 32'd0);

        // reset together with redirect and stall
        step(1, 1, 1, 32'h0040_0100, 0, 0, 32'h0040_0000, 32'd0, 32'd0, 1'b0, 1'b0, 32'd0);
        run1(32'h0040_0004, 32'h2402_0002, 32'h0040_0004, 32'd1);

        @(negedge clk);
        @(negedge clk);
        n_checks++;
        if (exp_q.size() != 0) begin
            n_fail++;
            $display("FAIL drain: %0d expectations left, expected 0", exp_q.size());
        end
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #50000;
        $display("FAIL timeout: bench did not complete within 50000 time units");
        $fatal(1, "timeout");
    end

endmodule
